fir_interp2_serial: RTL and testbench
=====================================

Name: fir_interp2_serial

Overview:
- Transmit-side 2x interpolating FIR. It is the upsampling counterpart of the team's 37-tap symmetric decimation/receive FIR.
- It uses the same 37-tap coefficient set, split into two polyphase branches: even taps h[0],h[2],…,h[36] (19 taps) and odd taps h[1],…,h[35] (18 taps).
- All products are computed by one time-multiplexed multiplier-accumulator.
- Input and output use valid/ready handshakes. The block sits between the sample source and the DAC-rate datapath.

Parameters:
- WL, 14, input sample and coefficient width (signed).
- MAC_WL, 20, output sample width (signed).
- TAP_NUM, 37, prototype filter length.
- ACC_WL, 34, accumulator width (28-bit product plus 19-term growth, with margin).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  data_in is valid
- in_ready  out  1  block can accept a sample
- data_in  in  WL  signed input sample
- out_valid  out  1  data_out is valid
- out_ready  in  1  downstream accepts data_out
- data_out  out  MAC_WL  signed interpolated sample
- out_phase  out  1  0 = even-phase output, 1 = odd-phase output

Behaviour:
- Coefficients are symmetric: h[k] = h[36-k]. The values for h[0..18] are:
  -19, -68, 0, 120, 60, -166, -176, 169, 344, -89, -557, -134, 781, 592, -982, -1588, 1120, 5819, 8191.
- Output definition: y[2n+p] = (sum over m of h[2m+p]·x[n-m]) >>> 13, with arithmetic shift (floor), then truncated to MAC_WL.
  - m runs 0..18 for p=0 and 0..17 for p=1.
  - Overflow is impossible for this set: sum|h| < 2^19.
- Delay line: 19 × WL registers holding x[n]..x[n-18]. It shifts only on an input handshake (in_valid & in_ready at a clock edge). It is reset to zero.
- FSM states: IDLE, MAC0, OUT0, MAC1, OUT1.
  - IDLE: in_ready=1. On input handshake, shift data_in into the delay line, clear the accumulator, set m=0, go to MAC0.
  - MAC0: 19 cycles, m=0..18, acc += h[2m]·x[n-m].
    - On the m=18 edge, data_out is loaded with (acc + last product) >>> 13, out_phase is set to 0, out_valid is set to 1, and the FSM goes to OUT0.
  - OUT0: hold data_out, out_valid and out_phase stable.
    - On the out_valid & out_ready edge: clear out_valid, clear acc, set m=0, go to MAC1.
  - MAC1: 18 cycles, m=0..17, acc += h[2m+1]·x[n-m]. On the last edge, load data_out, set out_phase=1, set out_valid=1, go to OUT1.
  - OUT1: on handshake, clear out_valid and go to IDLE.
- in_ready is 1 only in IDLE. While busy, in_valid is ignored and the delay line is unchanged.
- Latency:
  - out_valid rises 19 edges after the input-accept edge.
  - The phase-1 out_valid rises 18 edges after the phase-0 handshake edge.
  - With out_ready held at 1, one input is accepted every 40 cycles.
- Backpressure: out_ready low stalls indefinitely in OUT0/OUT1. data_out is never modified while out_valid=1.
- Reset values: out_valid=0, data_out=0, out_phase=0, state=IDLE (so in_ready=1 after reset), acc=0, m=0, delay line all zero.
- Reset mid-operation: all of the above is restored immediately and any partial sample is discarded.
- Accumulator arithmetic: full precision, signed, ACC_WL bits. Truncation happens only at the output load.

Decomposition:
- Shared package fir_coef_pkg holds:
  - WL, MAC_WL, TAP_NUM, FOLD_LEN=19, COEF_SHIFT=13
  - the coefficient constant array H_HALF[0:18]
  - the FSM state enumeration
  - The receive FIR is to migrate to this package later.
- One sub-module, fir_coef_rom: combinational, tap index 0..36 → coefficient. It mirrors indices above 18 to 36-k.

Test Plan:
- Reset: assert rst_n=0 mid-MAC0 → out_valid=0, data_out=0, in_ready=1 immediately. The next impulse response matches a fresh-start response.
- Impulse: input 8191 then zeros, out_ready=1 → outputs k=0..36 equal (h[k]·8191)>>>13: k0=-19, k1=-68, k18=8190, k36=-19. Outputs for k≥37 are 0. out_phase alternates 0,1.
- DC: constant 1000 for ≥20 inputs → steady state even-phase output 1139 (9333·1000>>>13) and odd-phase output 1136 (9310·1000>>>13).
- Backpressure: out_ready=0 for 10 cycles in OUT0 while in_valid pulses → data_out, out_phase and out_valid stable, in_ready=0, delay line unchanged. On release, responses are identical to the unstalled run.
- Throughput/latency: in_valid=1 and out_ready=1 continuously → an input is accepted every 40 cycles. First out_valid comes 19 cycles after the accept edge; second comes 19 cycles after the first (1 handshake edge + 18 MAC edges).
- Symmetry: random inputs over 500 samples, compared against a bit-exact reference model that zero-stuffs by 2, convolves with all 37 taps, then applies >>>13 → zero mismatches.

Source files
------------

// File: rtl/fir_coef_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_coef_pkg
// Description : Shared constants, coefficient half-table and FSM states for
//               the 37-tap symmetric FIR family.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_coef_pkg;

    localparam int WL         = 14;
    localparam int MAC_WL     = 20;
    localparam int TAP_NUM    = 37;
    localparam int FOLD_LEN   = 19;
    localparam int COEF_SHIFT = 13;
    localparam int ACC_WL     = 34;

    // h[0..18]; h[k] = h[36-k] supplies the upper half.
    localparam logic signed [WL-1:0] H_HALF [0:FOLD_LEN-1] = '{
        -14'sd19,   -14'sd68,   14'sd0,     14'sd120,   14'sd60,
        -14'sd166,  -14'sd176,  14'sd169,   14'sd344,   -14'sd89,
        -14'sd557,  -14'sd134,  14'sd781,   14'sd592,   -14'sd982,
        -14'sd1588, 14'sd1120,  14'sd5819,  14'sd8191
    };

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAC0 = 3'd1,
        ST_OUT0 = 3'd2,
        ST_MAC1 = 3'd3,
        ST_OUT1 = 3'd4
    } fsm_state_t;

endpackage : fir_coef_pkg
`default_nettype wire

// File: rtl/fir_interp2_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_interp2_serial_if
// Description : Input/output valid-ready streams of the 2x interpolating FIR.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_interp2_serial_if
    import fir_coef_pkg::*;
#(
    parameter int DATA_WL = WL,
    parameter int OUT_WL  = MAC_WL
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [DATA_WL-1:0] data_in;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [OUT_WL-1:0]  data_out;
    logic                      out_phase;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, out_phase
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, out_phase
    );
endinterface : fir_interp2_serial_if
`default_nettype wire

// File: rtl/fir_coef_rom.sv
`default_nettype none
// ============================================================================
// Module      : fir_coef_rom
// Description : Combinational tap index (0..36) to coefficient lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_coef_rom
    import fir_coef_pkg::*;
(
    input  wire logic        [5:0]    i_tap,
    output      logic signed [WL-1:0] o_coef
);
    logic [5:0] w_idx;

    always_comb begin
        w_idx  = (i_tap <= 6'(FOLD_LEN-1)) ? i_tap : (6'(TAP_NUM-1) - i_tap);
        o_coef = '0;
        if (w_idx < 6'(FOLD_LEN)) begin
            o_coef = H_HALF[w_idx[4:0]];
        end
    end
endmodule : fir_coef_rom
`default_nettype wire

// File: rtl/fir_interp2_serial.sv
`default_nettype none
// ============================================================================
// Module      : fir_interp2_serial
// Description : 2x polyphase interpolating FIR, 37 taps, one shared MAC.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_interp2_serial
    import fir_coef_pkg::*;
#(
    parameter int ACC_WL_P = ACC_WL
)
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    fir_interp2_serial_if.slave bus
);
    fsm_state_t                  r_state;
    fsm_state_t                  w_state_nxt;
    logic signed [WL-1:0]        r_dly [0:FOLD_LEN-1];
    logic signed [ACC_WL_P-1:0]  r_acc;
    logic        [4:0]           r_m;
    logic                        r_out_valid;
    logic signed [MAC_WL-1:0]    r_data_out;
    logic                        r_out_phase;

    logic                        w_in_hs;
    logic                        w_out_hs;
    logic                        w_last;
    logic        [5:0]           w_tap;
    logic signed [WL-1:0]        w_coef;
    logic signed [WL-1:0]        w_x;
    logic signed [2*WL-1:0]      w_prod;
    logic signed [ACC_WL_P-1:0]  w_sum;

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = r_data_out;
    assign bus.out_phase = r_out_phase;

    assign w_in_hs  = bus.in_valid & (r_state == ST_IDLE);
    assign w_out_hs = r_out_valid & bus.out_ready;
    assign w_last   = ((r_state == ST_MAC0) && (r_m == 5'(FOLD_LEN-1))) ||
                      ((r_state == ST_MAC1) && (r_m == 5'(FOLD_LEN-2)));

    // Even branch uses taps 2m, odd branch taps 2m+1, both against x[n-m].
    assign w_tap  = {r_m, (r_state == ST_MAC1)};
    assign w_x    = r_dly[r_m];
    assign w_prod = w_coef * w_x;
    assign w_sum  = r_acc + {{(ACC_WL_P-2*WL){w_prod[2*WL-1]}}, w_prod};

    fir_coef_rom u_rom (
        .i_tap  (w_tap),
        .o_coef (w_coef)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_in_hs)  w_state_nxt = ST_MAC0;
            ST_MAC0: if (w_last)   w_state_nxt = ST_OUT0;
            ST_OUT0: if (w_out_hs) w_state_nxt = ST_MAC1;
            ST_MAC1: if (w_last)   w_state_nxt = ST_OUT1;
            ST_OUT1: if (w_out_hs) w_state_nxt = ST_IDLE;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FOLD_LEN; i++) begin
                r_dly[i] <= '0;
            end
            r_acc       <= '0;
            r_m         <= '0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_out_phase <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_hs) begin
                        r_dly[0] <= bus.data_in;
                        for (int i = 1; i < FOLD_LEN; i++) begin
                            r_dly[i] <= r_dly[i-1];
                        end
                        r_acc <= '0;
                        r_m   <= '0;
                    end
                end
                ST_MAC0, ST_MAC1: begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        // Floor shift by COEF_SHIFT then truncate to MAC_WL.
                        r_data_out  <= w_sum[COEF_SHIFT +: MAC_WL];
                        r_out_phase <= (r_state == ST_MAC1);
                        r_out_valid <= 1'b1;
                    end else begin
                        r_m <= r_m + 5'd1;
                    end
                end
                ST_OUT0: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_m         <= '0;
                    end
                end
                ST_OUT1: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule : fir_interp2_serial
`default_nettype wire

// File: tb/tb_fir_interp2_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_interp2_serial
// Description : Self-checking bench for fir_interp2_serial against a
//               zero-stuff-and-convolve reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_interp2_serial;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   chk_from = 0;

    int                     h [0:36];
    int                     hh [0:18] = '{-19, -68, 0, 120, 60, -166, -176, 169, 344, -89,
                                          -557, -134, 781, 592, -982, -1588, 1120, 5819, 8191};
    int                     xs [$];
    logic signed [31:0]     got_d [$];
    logic                   got_p [$];
    int                     got_c [$];
    int                     acc_c [$];
    logic signed [31:0]     imp [0:41];

    fir_interp2_serial_if bus ();

    fir_interp2_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) acc_c.push_back(cyc);
            if (bus.out_valid && bus.out_ready) begin
                got_d.push_back(32'(bus.data_out));
                got_p.push_back(bus.out_phase);
                got_c.push_back(cyc);
            end
        end
    end

    // y[j] over the zero-stuffed input u: u[2n]=x[n], u[2n+1]=0.
    function automatic logic signed [31:0] ref_y(input int j);
        longint acc = 0;
        for (int k = 0; k < 37; k++) begin
            int t = j - k;
            if (t >= 0 && (t % 2) == 0 && (t / 2) < xs.size())
                acc += longint'(h[k]) * longint'(xs[t/2]);
        end
        return 32'(acc >>> 13);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    // Called at a negedge; returns at a negedge after the accept edge.
    task automatic push(input logic signed [13:0] x, input bit hold);
        int n = 0;
        bus.data_in  = x;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            timeout_fail("push_timeout");
            bus.in_valid = 1'b0;
        end else begin
            xs.push_back(int'(x));
            @(negedge clk);
            if (!hold) bus.in_valid = 1'b0;
        end
    endtask

    task automatic check_stream(input string tag);
        int n = 0;
        while (got_d.size() < 2 * xs.size() && n < 70000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 70000) timeout_fail({tag, "_wait"});
        chk({tag, "_count"}, got_d.size(), 2 * xs.size());
        for (int j = chk_from; j < 2 * xs.size() && j < got_d.size(); j++) begin
            chk({tag, "_data"}, got_d[j], ref_y(j));
            chk({tag, "_phase"}, 32'(got_p[j]), 32'(j % 2));
        end
        chk_from = 2 * xs.size();
    endtask

    initial begin
        int ai, oi, n, sent, last;
        logic signed [31:0] d0;
        logic               p0;

        for (int k = 0; k < 37; k++) h[k] = hh[(k <= 18) ? k : 36 - k];
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_data_out", 32'(bus.data_out), 0);
        chk("rst_out_phase", 32'(bus.out_phase), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Impulse response
        push(14'sd8191, 1'b0);
        for (int i = 0; i < 20; i++) push(14'sd0, 1'b0);
        check_stream("impulse");
        chk("imp_k0", got_d[0], -19);
        chk("imp_k1", got_d[1], -68);
        chk("imp_k18", got_d[18], 8190);
        chk("imp_k36", got_d[36], -19);
        chk("imp_k37", got_d[37], 0);
        for (int k = 0; k < 42; k++) imp[k] = got_d[k];

        // DC steady state
        for (int i = 0; i < 25; i++) push(14'sd1000, 1'b0);
        check_stream("dc");
        last = got_d.size() - 1;
        chk("dc_even", got_d[last-1], 1139);
        chk("dc_odd", got_d[last], 1136);

        // Backpressure in OUT0 with ignored input pulses
        bus.out_ready = 1'b0;
        push(14'(int'($urandom_range(0, 16383))), 1'b0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout_fail("bp_wait_valid");
        d0 = 32'(bus.data_out);
        p0 = bus.out_phase;
        chk("bp_phase0", 32'(p0), 0);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.data_in  = 14'($urandom);
            @(posedge clk);
            #1;
            chk("bp_data_stable", 32'(bus.data_out), d0);
            chk("bp_phase_stable", 32'(bus.out_phase), 32'(p0));
            chk("bp_valid_stable", 32'(bus.out_valid), 1);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(14'($urandom), 1'b0);
        check_stream("bp");

        // Throughput / latency with in_valid and out_ready held high
        ai = acc_c.size();
        oi = got_c.size();
        for (int i = 0; i < 4; i++) push(14'($urandom), 1'b1);
        bus.in_valid = 1'b0;
        check_stream("thru");
        for (int s = 0; s < 4; s++) begin
            if (s < 3) chk("thru_accept_gap", acc_c[ai+s+1] - acc_c[ai+s], 40);
            // Capture edge is one after out_valid rises.
            chk("thru_lat0", got_c[oi+2*s] - acc_c[ai+s], 20);
            chk("thru_lat1", got_c[oi+2*s+1] - got_c[oi+2*s], 19);
        end

        // Reset in the middle of MAC0
        push(14'sd5000, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_data_out", 32'(bus.data_out), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
        xs.delete();
        got_d.delete();
        got_p.delete();
        got_c.delete();
        chk_from = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(14'sd8191, 1'b0);
        for (int i = 0; i < 20; i++) push(14'sd0, 1'b0);
        check_stream("imp2");
        for (int k = 0; k < 42; k++) chk("imp2_vs_fresh", got_d[k], imp[k]);

        // Random inputs with random output backpressure
        sent = 0;
        n = 0;
        while ((sent < 500 || got_d.size() < 2 * xs.size()) && n < 60000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.in_ready && sent < 500 && $urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b1;
                bus.data_in  = 14'($urandom);
                xs.push_back(int'(bus.data_in));
                sent++;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        if (n >= 60000) timeout_fail("rand_budget");
        check_stream("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule : tb_fir_interp2_serial
`default_nettype wire
